// File: rtl/monitor_pkg.sv
// Shared types and limits for the implication monitor.
package monitor_pkg;

  typedef enum logic {
    RUN    = 1'b0,
    HALTED = 1'b1
  } mon_state_e;

  localparam int unsigned MAX_DELAY     = 16;
  localparam int unsigned DEFAULT_CNT_W = 16;

  // True when a DELAY value can be tracked by the pending shift register.
  function automatic bit delay_legal(input int unsigned d);
    return (d >= 1) && (d <= MAX_DELAY);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module sat_counter
  import monitor_pkg::*;
#(
  parameter int unsigned W = DEFAULT_CNT_W
) (
  input  logic         CLK,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count
);

  localparam logic [W-1:0] CNT_MAX = '1;

  // Clear wins; otherwise count up until the ceiling.
  always_ff @(posedge CLK) begin
    if (clr) begin
      count <= '0;
    end else if (inc && (count != CNT_MAX)) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/implication_monitor.sv
// Synthesizable checker for "antecedent |-> ##DELAY consequent".
// Tracks every in-flight obligation in a shift register, counts
// passes/failures, pulses fail and captures the first failure time.
module implication_monitor
  import monitor_pkg::*;
#(
  parameter int unsigned DELAY        = 1,
  parameter int unsigned CNT_W        = DEFAULT_CNT_W,
  parameter bit          STOP_ON_FAIL = 1'b0
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             enable,
  input  logic             antecedent,
  input  logic             consequent,
  input  logic             clear,
  output logic             fail,
  output logic             fail_sticky,
  output logic             state,
  output logic [CNT_W-1:0] pass_count,
  output logic [CNT_W-1:0] fail_count,
  output logic [CNT_W-1:0] first_fail_cycle
);

  // Refuse to elaborate with a delay the shift register cannot represent.
  generate
    if (!delay_legal(DELAY)) begin : g_bad_delay
      $error("implication_monitor: DELAY must be within 1..16");
    end
  endgenerate

  mon_state_e       st;
  logic [DELAY-1:0] pend;
  logic [CNT_W-1:0] cyc;
  logic             soft_clr_c;
  logic             check_c;
  logic             check_pass_c;
  logic             check_fail_c;

  // A maturing obligation is only judged while running and not being cleared.
  always_comb begin
    soft_clr_c   = RESET | clear;
    check_c      = pend[DELAY-1] & (st == RUN) & ~soft_clr_c;
    check_pass_c = check_c & consequent;
    check_fail_c = check_c & ~consequent;
  end

  // Free-running cycle timer used for the first-failure timestamp.
  sat_counter #(.W(CNT_W)) u_cyc (
    .CLK   (CLK),
    .clr   (soft_clr_c),
    .inc   (1'b1),
    .count (cyc)
  );

  sat_counter #(.W(CNT_W)) u_pass_cnt (
    .CLK   (CLK),
    .clr   (soft_clr_c),
    .inc   (check_pass_c),
    .count (pass_count)
  );

  sat_counter #(.W(CNT_W)) u_fail_cnt (
    .CLK   (CLK),
    .clr   (soft_clr_c),
    .inc   (check_fail_c),
    .count (fail_count)
  );

  // Pending obligations: bit i is a trigger seen i+1 cycles ago.
  always_ff @(posedge CLK) begin
    if (soft_clr_c || (st == HALTED)) begin
      pend <= '0;
    end else begin
      pend <= DELAY'({pend, enable & antecedent});
    end
  end

  // Run/halt FSM, registered fail pulse and first-failure capture.
  always_ff @(posedge CLK) begin
    if (soft_clr_c) begin
      st               <= RUN;
      fail             <= 1'b0;
      fail_sticky      <= 1'b0;
      first_fail_cycle <= '0;
    end else begin
      fail <= check_fail_c;
      if (check_fail_c && !fail_sticky) begin
        fail_sticky      <= 1'b1;
        first_fail_cycle <= cyc;
      end
      case (st)
        RUN:     if (check_fail_c && STOP_ON_FAIL) st <= HALTED;
        HALTED:  st <= HALTED;
        default: st <= RUN;
      endcase
    end
  end

  assign state = (st == HALTED);

endmodule
